// File: rtl/traffic_light.sv
// Fixed-time RED -> GREEN -> YELLOW traffic light controller.
// Dwell times are counted in ticks from a free-running prescaler; the lamps are registered.
module traffic_light #(
  parameter int unsigned TICK_DIV     = 1,
  parameter int unsigned RED_TICKS    = 50,
  parameter int unsigned GREEN_TICKS  = 40,
  parameter int unsigned YELLOW_TICKS = 10
) (
  input  logic Clock,
  input  logic Reset_n,
  output logic R_LED,
  output logic Y_LED,
  output logic G_LED
);

  function automatic int unsigned at_least_one(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  // Bits needed to hold the values 0..n-1.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n <= 2) ? 1 : int'($clog2(n));
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int unsigned DIV_EFF    = at_least_one(TICK_DIV);
  localparam int unsigned RED_EFF    = at_least_one(RED_TICKS);
  localparam int unsigned GREEN_EFF  = at_least_one(GREEN_TICKS);
  localparam int unsigned YELLOW_EFF = at_least_one(YELLOW_TICKS);
  localparam int unsigned DUR_MAX    = max3(RED_EFF, GREEN_EFF, YELLOW_EFF);
  localparam int unsigned PS_W       = bits_for(DIV_EFF);
  localparam int unsigned DW_W       = bits_for(DUR_MAX);

  localparam logic [PS_W-1:0] PS_LAST     = PS_W'(DIV_EFF - 1);
  localparam logic [DW_W-1:0] RED_LAST    = DW_W'(RED_EFF - 1);
  localparam logic [DW_W-1:0] GREEN_LAST  = DW_W'(GREEN_EFF - 1);
  localparam logic [DW_W-1:0] YELLOW_LAST = DW_W'(YELLOW_EFF - 1);

  localparam logic [1:0] ST_RED    = 2'b00;
  localparam logic [1:0] ST_GREEN  = 2'b01;
  localparam logic [1:0] ST_YELLOW = 2'b10;

  // Lamp vector ordering is {red, yellow, green}.
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  logic [1:0]      sync_q, sync_d;
  logic            run;
  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick;
  logic [1:0]      state_q, state_d;
  logic [1:0]      state_next;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [DW_W-1:0] dwell_last;
  logic            state_legal;
  logic [2:0]      lamp_q, lamp_d;

  // Reset release is brought into the clock domain before anything starts counting.
  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign run = sync_q[1];

  always_comb begin
    tick = run && (ps_q == PS_LAST);
    ps_d = ps_q;
    if (tick) begin
      ps_d = '0;
    end else if (run) begin
      ps_d = ps_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_RED;
      dwell_q <= '0;
      lamp_q  <= LAMP_R;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      lamp_q  <= lamp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    dwell_last  = RED_LAST;
    state_next  = ST_GREEN;
    state_legal = 1'b1;
    case (state_q)
      ST_RED: begin
        dwell_last = RED_LAST;
        state_next = ST_GREEN;
      end
      ST_GREEN: begin
        dwell_last = GREEN_LAST;
        state_next = ST_YELLOW;
      end
      ST_YELLOW: begin
        dwell_last = YELLOW_LAST;
        state_next = ST_RED;
      end
      default: state_legal = 1'b0;
    endcase

    // A corrupted state register recovers to RED regardless of tick or reset sync.
    if (!state_legal) begin
      state_d = ST_RED;
      dwell_d = '0;
    end else if (tick) begin
      if (dwell_q == dwell_last) begin
        state_d = state_next;
        dwell_d = '0;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  // Lamps decode the next state so they change on the same edge as the state register.
  always_comb begin
    case (state_d)
      ST_GREEN:  lamp_d = LAMP_G;
      ST_YELLOW: lamp_d = LAMP_Y;
      default:   lamp_d = LAMP_R;
    endcase
  end

  assign R_LED = lamp_q[2];
  assign Y_LED = lamp_q[1];
  assign G_LED = lamp_q[0];

endmodule

// File: tb/tb_traffic_light.sv
// Bench for traffic_light: three parameterisations run side by side; lamp segment lengths
// are queued as expectations and compared as each segment ends.
`timescale 1ns/100ps
module tb_traffic_light;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic r0, y0, g0, r1, y1, g1, r2, y2, g2;
  logic [2:0] leds [3];

  always #5 clk = ~clk;

  traffic_light dut0 (
    .Clock(clk), .Reset_n(rst_n), .R_LED(r0), .Y_LED(y0), .G_LED(g0)
  );

  traffic_light #(
    .TICK_DIV(4), .RED_TICKS(2), .GREEN_TICKS(3), .YELLOW_TICKS(1)
  ) dut1 (
    .Clock(clk), .Reset_n(rst_n), .R_LED(r1), .Y_LED(y1), .G_LED(g1)
  );

  traffic_light #(
    .TICK_DIV(2), .RED_TICKS(3), .GREEN_TICKS(0), .YELLOW_TICKS(2)
  ) dut2 (
    .Clock(clk), .Reset_n(rst_n), .R_LED(r2), .Y_LED(y2), .G_LED(g2)
  );

  assign leds[0] = {r0, y0, g0};
  assign leds[1] = {r1, y1, g1};
  assign leds[2] = {r2, y2, g2};

  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;

  typedef struct {
    int unsigned phase;
    int unsigned dut;
    logic [2:0]  lamps;
    int unsigned len;
  } seg_t;

  localparam int NVEC = 23;
  seg_t vec [NVEC];
  seg_t exp_q [3][$];

  int checks = 0;
  int errors = 0;

  logic        mon_en  [3];
  logic [2:0]  mon_cur [3];
  int unsigned mon_run [3];

  // Per-cycle one-hot check plus segment-length scoreboard.
  always @(negedge clk) begin
    seg_t e;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (!$onehot(leds[i])) begin
        errors++;
        $display("FAIL onehot dut%0d lamps=%b required exactly one lit", i, leds[i]);
      end
      if (mon_en[i]) begin
        if (leds[i] == mon_cur[i]) begin
          mon_run[i]++;
        end else begin
          if (exp_q[i].size() > 0) begin
            e = exp_q[i].pop_front();
            checks++;
            if (mon_cur[i] !== e.lamps || mon_run[i] != e.len) begin
              errors++;
              $display("FAIL segment dut%0d lamps=%b len=%0d required lamps=%b len=%0d",
                       i, mon_cur[i], mon_run[i], e.lamps, e.len);
            end
          end
          mon_cur[i] = leds[i];
          mon_run[i] = 1;
        end
      end
    end
  end

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s lamps=%b required %b", name, act, req);
    end
  endtask

  task automatic start_mon(input int i);
    exp_q[i].delete();
    mon_cur[i] = leds[i];
    mon_run[i] = 0;
    mon_en[i]  = 1'b1;
  endtask

  task automatic push_phase(input int unsigned p);
    for (int k = 0; k < NVEC; k++) begin
      if (vec[k].phase == p) exp_q[vec[k].dut].push_back(vec[k]);
    end
  endtask

  // Deassert between edges; measurement starts once the two-flop synchroniser has released.
  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d pending=%0d required 0", i, exp_q[i].size());
      end
    end
  endtask

  task automatic wait_green0(input int budget);
    int n;
    n = 0;
    while (g0 !== 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (g0 !== 1'b1) begin
      errors++;
      $display("FAIL wait_green dut0 g=%b required 1", g0);
    end
  endtask

  initial begin
    vec[0]  = '{1, 0, LR, 50}; vec[1]  = '{1, 0, LG, 40}; vec[2]  = '{1, 0, LY, 10};
    vec[3]  = '{1, 0, LR, 50}; vec[4]  = '{1, 0, LG, 40}; vec[5]  = '{1, 0, LY, 10};
    vec[6]  = '{1, 1, LR, 8};  vec[7]  = '{1, 1, LG, 12}; vec[8]  = '{1, 1, LY, 4};
    vec[9]  = '{1, 1, LR, 8};  vec[10] = '{1, 1, LG, 12}; vec[11] = '{1, 1, LY, 4};
    vec[12] = '{1, 2, LR, 6};  vec[13] = '{1, 2, LG, 2};  vec[14] = '{1, 2, LY, 4};
    vec[15] = '{1, 2, LR, 6};  vec[16] = '{1, 2, LG, 2};  vec[17] = '{1, 2, LY, 4};
    vec[18] = '{2, 0, LR, 50}; vec[19] = '{2, 0, LG, 40};
    vec[20] = '{3, 0, LR, 50}; vec[21] = '{3, 0, LG, 40}; vec[22] = '{3, 0, LY, 10};
    for (int i = 0; i < 3; i++) begin
      mon_en[i]  = 1'b0;
      mon_cur[i] = 3'b000;
      mon_run[i] = 0;
    end

    // Reset asserted before any clock edge: lamps must already show RED.
    #1 rst_n = 1'b0;
    #2;
    check3("reset_noclk_dut0", leds[0], LR);
    check3("reset_noclk_dut1", leds[1], LR);
    check3("reset_noclk_dut2", leds[2], LR);
    repeat (4) @(posedge clk);
    #1;
    check3("reset_held_dut0", leds[0], LR);
    check3("reset_held_dut1", leds[1], LR);
    check3("reset_held_dut2", leds[2], LR);

    // Two full periods on every configuration.
    release_reset();
    for (int i = 0; i < 3; i++) start_mon(i);
    push_phase(1);
    drain(400);

    // Asynchronous reset in the middle of GREEN.
    for (int i = 0; i < 3; i++) mon_en[i] = 1'b0;
    wait_green0(200);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #0.1;
    check3("async_rst_dut0", leds[0], LR);
    check3("async_rst_dut1", leds[1], LR);
    check3("async_rst_dut2", leds[2], LR);
    repeat (3) @(posedge clk);
    #1;
    check3("async_rst_held_dut0", leds[0], LR);
    release_reset();
    start_mon(0);
    push_phase(2);
    drain(300);

    // Corrupt the state register during GREEN; recovery to RED on the next edge.
    mon_en[0] = 1'b0;
    wait_green0(200);
    repeat (5) @(posedge clk);
    @(negedge clk);
    force dut0.state_q = 2'b11;
    #1;
    release dut0.state_q;
    check3("illegal_before_edge", leds[0], LG);
    @(posedge clk);
    #1;
    check3("illegal_to_red", leds[0], LR);
    start_mon(0);
    push_phase(3);
    drain(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light.md
TRAFFIC_LIGHT -- requirements
Module: traffic_light

Interface
REQ-001 Parameter TICK_DIV, default 1: clock cycles per timing tick; legal range 1..65535.
REQ-002 Parameter RED_TICKS, default 50: ticks spent in RED; legal range 1..65535.
REQ-003 Parameter GREEN_TICKS, default 40: ticks spent in GREEN; legal range 1..65535.
REQ-004 Parameter YELLOW_TICKS, default 10: ticks spent in YELLOW; legal range 1..65535.
REQ-005 Port Clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 Port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port R_LED, output, 1 bit: red lamp, high = lit.
REQ-008 Port Y_LED, output, 1 bit: yellow lamp, high = lit.
REQ-009 Port G_LED, output, 1 bit: green lamp, high = lit.

Function
REQ-010 The block SHALL be a Moore FSM with three legal states: RED, GREEN, YELLOW.
REQ-011 Cycle order SHALL be RED -> GREEN -> YELLOW -> RED, repeating indefinitely with no external input besides Clock and Reset_n.
REQ-012 Each lamp output SHALL be a registered decode of the state register (no combinational path from any input).
REQ-013 Exactly one of R_LED, Y_LED, G_LED SHALL be high in every cycle, including the cycle after any transition.
REQ-014 A prescaler SHALL count 0..TICK_DIV-1 and assert an internal tick on the cycle it holds TICK_DIV-1, then wrap to 0; with TICK_DIV=1, tick SHALL be high every cycle.
REQ-015 A dwell counter SHALL increment on each tick, and on the tick where it equals the current state's duration minus 1 it SHALL clear to 0 while the state advances.
REQ-016 Each state SHALL therefore last exactly duration x TICK_DIV clock cycles.
REQ-017 The prescaler SHALL run continuously and SHALL NOT be cleared on state transitions.
REQ-018 Counters SHALL be sized to the largest parameter value; no wrap-around SHALL occur before the terminal compare.
REQ-019 Any illegal state-register encoding SHALL force RED, with the dwell counter cleared, on the next rising edge, with R_LED high in that cycle.
REQ-020 A duration parameter of 0 SHALL be treated as 1.

Reset
REQ-021 While Reset_n is low: state = RED, dwell counter = 0, prescaler = 0, R_LED=1, Y_LED=0, G_LED=0, asserted immediately with no clock required.
REQ-022 Reset asserted mid-state SHALL abort the current dwell; after release, RED SHALL last a full RED_TICKS x TICK_DIV cycles.
REQ-023 Reset release SHALL be synchronised internally (two-flop deassertion synchroniser) so the first counting edge is well defined.

Verification
REQ-024 With defaults (100 MHz clock), release reset, then check: R_LED high for 50 cycles, G_LED high for the next 40, Y_LED high for the next 10, then R_LED again; full period = 100 cycles.
REQ-025 Over 1500 ns after reset release, check the one-hot property every cycle; zero violations are allowed.
REQ-026 With TICK_DIV=4, RED=2, GREEN=3, YELLOW=1, check state lengths of 8, 12 and 4 cycles.
REQ-027 Assert Reset_n low asynchronously (between edges) during GREEN: R_LED rises and G_LED falls within the same time step; after release, RED lasts a full 50 cycles.
REQ-028 Force an illegal state encoding: next rising edge gives R_LED=1, and the sequence then continues normally.
REQ-029 With GREEN_TICKS=0: GREEN lasts 1 x TICK_DIV cycles.
